// File: rtl/fact_inv_seq.sv
// Sequential inverse-factorial decoder.
// Steps fact <= fact*i, i <= i+1 (mod 2^W) once per cycle and reports the
// smallest n >= 1 whose n! mod 2^W equals the latched target, or not-found.
module fact_inv_seq #(
  parameter int W     = 8,
  parameter int MAX_N = 255
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] target,
  output logic         busy,
  output logic         done,
  output logic         found,
  output logic [W-1:0] n_out
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [W-1:0] LAST_N = W'(MAX_N);
  localparam logic [W-1:0] ONE    = W'(1);

  state_t       state, state_d;
  logic [W-1:0] target_q;
  logic [W-1:0] fact_q;
  logic [W-1:0] i_q;
  logic [W-1:0] prod;
  logic         accept;
  logic         hit;
  logic         zero;
  logic         last;
  logic         finish;

  // W x W multiply keeping only the low W bits; wrap-around is intended.
  function automatic logic [W-1:0] mul_trunc(input logic [W-1:0] a,
                                             input logic [W-1:0] b);
    logic [2*W-1:0] full;
    full = a * b;
    return full[W-1:0];
  endfunction

  // Next-state and round decisions. Match beats zero beats MAX_N so the
  // smallest matching n is always the one reported.
  always_comb begin
    state_d = state;
    accept  = 1'b0;
    hit     = 1'b0;
    zero    = 1'b0;
    last    = 1'b0;
    prod    = mul_trunc(fact_q, i_q);
    case (state)
      IDLE, DONE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = SEARCH;
        end
      end
      SEARCH: begin
        if (prod == target_q) begin
          hit = 1'b1;
        end else if (prod == '0) begin
          // Once the product wraps to zero it stays zero; no later n can
          // match a nonzero target.
          zero = 1'b1;
        end else if (i_q == LAST_N) begin
          last = 1'b1;
        end
        if (hit || zero || last) begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign finish = hit | zero | last;
  assign busy   = (state == SEARCH);

  // State register; reset returns to IDLE from anywhere.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Round registers and result outputs; done pulses on entry to DONE only.
  always_ff @(posedge clk) begin
    if (rst) begin
      fact_q <= '0;
      i_q    <= '0;
      found  <= 1'b0;
      n_out  <= '0;
      done   <= 1'b0;
    end else begin
      done <= finish;
      if (accept) begin
        fact_q <= ONE;
        i_q    <= ONE;
        found  <= 1'b0;
        n_out  <= '0;
      end else if (state == SEARCH) begin
        if (hit) begin
          found <= 1'b1;
          n_out <= i_q;
        end else if (zero || last) begin
          found <= 1'b0;
          n_out <= '0;
        end else begin
          fact_q <= prod;
          i_q    <= i_q + ONE;
        end
      end
    end
  end

  // Target is captured only when a request is accepted.
  always_ff @(posedge clk) begin
    if (accept) begin
      target_q <= target;
    end
  end

endmodule

// File: tb/tb_fact_inv_seq.sv
// Testbench for fact_inv_seq: directed and random targets checked against a
// plain-arithmetic inverse-factorial model.
module tb_fact_inv_seq;

  logic       clk;
  logic       rst;
  logic       start, start2;
  logic [7:0] target, target2;
  logic       busy, done, found;
  logic [7:0] n_out;
  logic       busy2, done2, found2;
  logic [7:0] n_out2;

  int errors = 0;
  int checks = 0;

  fact_inv_seq #(.W(8), .MAX_N(255)) dut (
    .clk(clk), .rst(rst), .start(start), .target(target),
    .busy(busy), .done(done), .found(found), .n_out(n_out)
  );

  fact_inv_seq #(.W(8), .MAX_N(5)) dut5 (
    .clk(clk), .rst(rst), .start(start2), .target(target2),
    .busy(busy2), .done(done2), .found(found2), .n_out(n_out2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Smallest n in 1..maxn with n! mod 256 == t; stops early when the
  // factorial becomes 0. lat is the number of candidates evaluated.
  task automatic model(input int t, input int maxn,
                       output bit f, output int n, output int lat);
    int fct;
    fct = 1;
    f   = 0;
    n   = 0;
    lat = maxn;
    for (int k = 1; k <= maxn; k++) begin
      fct = (fct * k) % 256;
      if (fct == t) begin
        f = 1; n = k; lat = k;
        return;
      end
      if (fct == 0) begin
        lat = k;
        return;
      end
    end
  endtask

  // Launch one search on the MAX_N=255 instance and check it; returns at
  // the sample where done is high.
  task automatic run(input logic [7:0] t, input string name);
    bit f_e;
    int n_e, lat_e, lat, bcnt;
    model(int'(t), 255, f_e, n_e, lat_e);
    target = t;
    start  = 1'b1;
    step();
    start  = 1'b0;
    target = $urandom_range(0, 255);
    lat  = 0;
    bcnt = 0;
    while (!done && lat < 300) begin
      if (busy) bcnt++;
      step();
      lat++;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s timeout: done never seen after %0d cycles, required %0d", name, lat, lat_e);
      return;
    end
    checks++;
    if (lat != lat_e) begin
      errors++;
      $display("FAIL %s latency: got %0d required %0d", name, lat, lat_e);
    end
    checks++;
    if (bcnt != lat_e) begin
      errors++;
      $display("FAIL %s busy cycles: got %0d required %0d", name, bcnt, lat_e);
    end
    checks++;
    if (found !== f_e || n_out !== 8'(n_e) || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s result: found=%0b n_out=%0d busy=%0b required found=%0b n_out=%0d busy=0",
               name, found, n_out, busy, f_e, n_e);
    end
  endtask

  // After a completed run: done drops, result holds, stays idle-ish.
  task automatic check_hold(input string name);
    logic       f0;
    logic [7:0] n0;
    f0 = found;
    n0 = n_out;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || found !== f0 || n_out !== n0) begin
        errors++;
        $display("FAIL %s hold: done=%0b busy=%0b found=%0b n_out=%0d required 0 0 %0b %0d",
                 name, done, busy, found, n_out, f0, n0);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || found !== 1'b0 || n_out !== 8'd0) begin
      errors++;
      $display("FAIL reset: busy=%0b done=%0b found=%0b n_out=%0d required all 0",
               busy, done, found, n_out);
    end
    step();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || busy2 !== 1'b0 || done2 !== 1'b0) begin
      errors++;
      $display("FAIL reset idle: busy=%0b done=%0b busy2=%0b done2=%0b required 0",
               busy, done, busy2, done2);
    end
  endtask

  task automatic test_directed();
    run(8'd24, "t24");
    checks++;
    if (n_out !== 8'd4) begin
      errors++;
      $display("FAIL t24 n: got %0d required 4", n_out);
    end
    check_hold("t24");
    run(8'd128, "t128");
    checks++;
    if (n_out !== 8'd8) begin
      errors++;
      $display("FAIL t128 n: got %0d required 8", n_out);
    end
    check_hold("t128");
    run(8'd0, "t0");
    run(8'd7, "t7");
    check_hold("t7");
    run(8'd1, "t1");
  endtask

  task automatic test_max_n();
    int lat;
    target2 = 8'd208;
    start2  = 1'b1;
    step();
    start2 = 1'b0;
    lat = 0;
    while (!done2 && lat < 50) begin
      step();
      lat++;
    end
    checks++;
    if (done2 !== 1'b1 || lat != 5 || found2 !== 1'b0 || n_out2 !== 8'd0) begin
      errors++;
      $display("FAIL maxn: done=%0b lat=%0d found=%0b n_out=%0d required 1 5 0 0",
               done2, lat, found2, n_out2);
    end
    target2 = 8'd120;
    start2  = 1'b1;
    step();
    start2 = 1'b0;
    lat = 0;
    while (!done2 && lat < 50) begin
      step();
      lat++;
    end
    checks++;
    if (done2 !== 1'b1 || lat != 5 || found2 !== 1'b1 || n_out2 !== 8'd5) begin
      errors++;
      $display("FAIL maxn hit: done=%0b lat=%0d found=%0b n_out=%0d required 1 5 1 5",
               done2, lat, found2, n_out2);
    end
  endtask

  task automatic test_back_to_back();
    // Each start is raised in the very cycle done is high.
    run(8'd24, "b2b0");
    run(8'd120, "b2b1");
    run(8'd176, "b2b2");
    check_hold("b2b2");
  endtask

  task automatic test_ignore_start();
    int lat;
    target = 8'd6;
    start  = 1'b1;
    step();
    target = 8'd24;
    step();
    start = 1'b0;
    lat = 1;
    while (!done && lat < 50) begin
      step();
      lat++;
    end
    checks++;
    if (done !== 1'b1 || lat != 3 || found !== 1'b1 || n_out !== 8'd3) begin
      errors++;
      $display("FAIL ignore: done=%0b lat=%0d found=%0b n_out=%0d required 1 3 1 3",
               done, lat, found, n_out);
    end
  endtask

  task automatic test_rst_mid();
    // Reset while holding a found result in DONE.
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (found !== 1'b0 || n_out !== 8'd0 || done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rst done: found=%0b n_out=%0d done=%0b busy=%0b required 0",
               found, n_out, done, busy);
    end
    // Reset in the middle of a 10-cycle search.
    target = 8'd0;
    start  = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || found !== 1'b0 || n_out !== 8'd0) begin
      errors++;
      $display("FAIL rst mid: busy=%0b done=%0b found=%0b n_out=%0d required 0",
               busy, done, found, n_out);
    end
    for (int k = 0; k < 12; k++) begin
      step();
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
        errors++;
        $display("FAIL rst idle cycle %0d: busy=%0b done=%0b required 0", k, busy, done);
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] t;
    for (int k = 0; k < 24; k++) begin
      if (k % 2 == 0) t = 8'($urandom_range(0, 255));
      else begin
        case ($urandom_range(0, 4))
          0: t = 8'd2;
          1: t = 8'd120;
          2: t = 8'd208;
          3: t = 8'd176;
          default: t = 8'd6;
        endcase
      end
      run(t, "rand");
      if ($urandom_range(0, 1) == 1) step();
    end
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; start2 = 1'b0;
    target = 8'd0; target2 = 8'd0;
    test_reset();
    test_directed();
    test_max_n();
    test_back_to_back();
    test_ignore_start();
    test_rst_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
